dsd_tdm_channel_combiner: RTL

DSD_TDM_CHANNEL_COMBINER -- requirements
Module: dsd_tdm_channel_combiner

---
 rtl/dsd_tdm_channel_combiner.sv | 116 +++++++++++
 1 files changed

// File: rtl/dsd_tdm_channel_combiner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dsd_tdm_channel_combiner
// Purpose  : Packs two serial DSD channels into a 32-slot TDM frame and
//            replaces full-scale or muted frames with a silence pattern.
// Revision : 1.0
// ============================================================================
module dsd_tdm_channel_combiner #(
    parameter int Ch_Width = 16
) (
    input  logic in_BCK,
    input  logic Reset,
    input  logic in_Ch0_Data,
    input  logic in_Ch1_Data,
    input  logic Protect_EN,
    input  logic Mute,
    output logic out_BCK,
    output logic out_Data,
    output logic FrameSync,
    output logic ProtectFlag
);

    localparam int                      c_FRAME_BITS = 2 * Ch_Width;
    localparam int                      c_CNT_W      = $clog2(c_FRAME_BITS);
    localparam logic [c_CNT_W-1:0]      c_LAST_BIT   = c_CNT_W'(c_FRAME_BITS - 1);
    localparam logic [c_FRAME_BITS-1:0] c_SILENCE    = {(c_FRAME_BITS / 8){8'h96}};
    localparam logic [1:0]              c_CLEAN_LAST = 2'd3;

    typedef enum logic [0:0] {
        ST_NORMAL  = 1'b0,
        ST_PROTECT = 1'b1
    } state_t;

    state_t                    r_state;
    logic [1:0]                r_cleanCnt;
    logic [c_CNT_W-1:0]        r_bitCount;
    logic [Ch_Width-1:0]       r_sh0;
    logic [Ch_Width-1:0]       r_sh1;
    logic [c_FRAME_BITS-1:0]   r_txReg;
    logic                      r_frameSync;

    logic                      w_load;
    logic [Ch_Width-1:0]       w_word0;
    logic [Ch_Width-1:0]       w_word1;
    logic                      w_det;
    logic                      w_nextProtect;

    // The load edge is also the 16th sample, so the current input bit completes each word.
    assign w_load  = (r_bitCount == c_LAST_BIT);
    assign w_word0 = {r_sh0[Ch_Width-2:0], in_Ch0_Data};
    assign w_word1 = {r_sh1[Ch_Width-2:0], in_Ch1_Data};
    assign w_det   = Protect_EN &&
                     ((w_word0 == '0) || (w_word0 == '1) ||
                      (w_word1 == '0) || (w_word1 == '1));

    // PROTECT persists unless this load is the fourth consecutive clean frame.
    assign w_nextProtect = w_det ||
                           ((r_state == ST_PROTECT) && (r_cleanCnt != c_CLEAN_LAST));

    always_ff @(posedge in_BCK or posedge Reset) begin
        if (Reset) begin
            r_bitCount  <= '0;
            r_sh0       <= '0;
            r_sh1       <= '0;
            r_txReg     <= c_SILENCE;
            r_frameSync <= 1'b0;
            r_state     <= ST_PROTECT;
            r_cleanCnt  <= 2'd0;
        end else begin
            r_bitCount  <= r_bitCount + c_CNT_W'(1);
            r_frameSync <= w_load;

            if (r_bitCount[0]) begin
                r_sh0 <= w_word0;
                r_sh1 <= w_word1;
            end

            if (w_load) begin
                case (r_state)
                    ST_NORMAL: begin
                        if (w_det) begin
                            r_state    <= ST_PROTECT;
                            r_cleanCnt <= 2'd0;
                        end
                    end
                    ST_PROTECT: begin
                        if (w_det) begin
                            r_cleanCnt <= 2'd0;
                        end else if (r_cleanCnt == c_CLEAN_LAST) begin
                            r_state    <= ST_NORMAL;
                            r_cleanCnt <= 2'd0;
                        end else begin
                            r_cleanCnt <= r_cleanCnt + 2'd1;
                        end
                    end
                    default: begin
                        r_state    <= ST_PROTECT;
                        r_cleanCnt <= 2'd0;
                    end
                endcase

                r_txReg <= (Mute || w_nextProtect) ? c_SILENCE : {w_word0, w_word1};
            end else begin
                r_txReg <= {r_txReg[c_FRAME_BITS-2:0], 1'b0};
            end
        end
    end

    assign out_BCK     = r_bitCount[0];
    assign out_Data    = r_txReg[c_FRAME_BITS-1];
    assign FrameSync   = r_frameSync;
    assign ProtectFlag = (r_state == ST_PROTECT);

endmodule
`default_nettype wire
